// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between the CPU controller (M0)
// and the DMA master (M1); one outstanding access, latched request, per-access timeout.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int AW  = 15,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_done,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_done,
    output logic          m1_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_readrdy,
    input  logic          mem_saverdy,
    output logic [1:0]    gnt
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t        state, next_state;
    logic          owner;        // 0 = M0, 1 = M1
    logic          last_owner;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [7:0]    cnt;
    logic          err_flag;
    logic          grant, grant_m1, complete, timeout, active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        // NOTE: defaults come first so every path assigns every signal and no latch is inferred.
        next_state = state;
        grant      = 1'b0;
        grant_m1   = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (m0_req && m1_req) begin
                    grant    = 1'b1;
                    grant_m1 = ~last_owner;
                end else if (m0_req) begin
                    grant    = 1'b1;
                end else if (m1_req) begin
                    grant    = 1'b1;
                    grant_m1 = 1'b1;
                end
                if (grant) next_state = S_ISSUE;
            end
            S_ISSUE: next_state = S_WAIT;
            S_WAIT: begin
                // Only the handshake matching the access direction can finish it.
                complete = lat_we ? mem_saverdy : mem_readrdy;
                timeout  = !complete && (cnt == TMO_LAST);
                if (complete || timeout) next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the read-data holding registers are visible outputs, so they are reset
        // along with the control state; they are plain registers, not a memory array.
        if (rst) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            err_flag   <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        owner     <= grant_m1;
                        lat_we    <= grant_m1 ? m1_we    : m0_we;
                        lat_addr  <= grant_m1 ? m1_addr  : m0_addr;
                        lat_wdata <= grant_m1 ? m1_wdata : m0_wdata;
                        err_flag  <= 1'b0;
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (complete) begin
                        if (!lat_we) begin
                            if (owner) m1_rdata <= mem_rdata;
                            else       m0_rdata <= mem_rdata;
                        end
                    end else if (timeout) begin
                        err_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE:  last_owner <= owner;
                default: ;
            endcase
        end
    end

    assign active    = (state == S_ISSUE) || (state == S_WAIT);
    assign gnt       = active ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign mem_addr  = active ? lat_addr  : '0;
    assign mem_wdata = active ? lat_wdata : '0;
    assign mem_rd    = (state == S_ISSUE) && !lat_we;
    assign mem_we    = (state == S_ISSUE) &&  lat_we;
    assign m0_done   = (state == S_DONE) && !owner;
    assign m1_done   = (state == S_DONE) &&  owner;
    assign m0_err    = m0_done && err_flag;
    assign m1_err    = m1_done && err_flag;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory strobes and
// completions into queues, a monitor pops and compares; a responder plays the memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW  = 15;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr, mem_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic          m0_done, m0_err, m1_done, m1_err;
    logic          mem_we, mem_rd, mem_readrdy, mem_saverdy;
    logic [1:0]    gnt;

    logic          resp_rr, resp_sr, stray_rr, stray_sr;
    logic [DW-1:0] resp_data;

    assign mem_readrdy = resp_rr | stray_rr;
    assign mem_saverdy = resp_sr | stray_sr;
    assign mem_rdata   = resp_data;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_readrdy(mem_readrdy), .mem_saverdy(mem_saverdy),
        .gnt(gnt)
    );

    typedef struct {logic m; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} mem_exp_t;
    typedef struct {logic m; logic err; logic [DW-1:0] rdata; int delta;} done_exp_t;
    typedef struct {int lat; logic [DW-1:0] data;} resp_t;

    mem_exp_t  mem_q[$];
    done_exp_t done_q[$];
    resp_t     resp_q[$];
    logic [DW-1:0] model_rd [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int issue_cyc = 0;

    // Fairness test vectors: per-master sequences, all with 1-cycle ready.
    logic          t3_we0 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [AW-1:0] t3_a0  [4] = '{15'h0010, 15'h0011, 15'h0012, 15'h0013};
    logic [DW-1:0] t3_wd0 [4] = '{32'h0, 32'h2222_2222, 32'h0, 32'h4444_4444};
    logic [DW-1:0] t3_rd0 [4] = '{32'h1111_1111, 32'h0, 32'h3333_3333, 32'h0};
    logic          t3_we1 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [AW-1:0] t3_a1  [4] = '{15'h7FFF, 15'h0000, 15'h4000, 15'h2AAA};
    logic [DW-1:0] t3_wd1 [4] = '{32'h0, 32'h5555_5555, 32'h6666_6666, 32'h0};
    logic [DW-1:0] t3_rd1 [4] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0001};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_zero();
        check("rst_gnt",       64'(gnt), 64'(0));
        check("rst_mem_addr",  64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_strobes",   64'({mem_we, mem_rd, m0_done, m1_done, m0_err, m1_err}), 64'(0));
        check("rst_m0_rdata",  64'(m0_rdata), 64'(0));
        check("rst_m1_rdata",  64'(m1_rdata), 64'(0));
    endtask

    // lat = cycle offset of the ready pulse after the strobe cycle; 0 = memory never answers.
    function automatic void push_access(input logic m, input logic we, input logic [AW-1:0] addr,
                                        input logic [DW-1:0] wdata, input int lat,
                                        input logic [DW-1:0] rdata);
        logic err;
        err = (lat == 0);
        mem_q.push_back('{m, we, addr, wdata});
        resp_q.push_back('{lat, rdata});
        if (!we && !err) model_rd[int'(m)] = rdata;
        done_q.push_back('{m, err, model_rd[int'(m)], err ? TMO + 1 : lat + 1});
    endfunction

    task automatic master_access(input logic m, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic keep);
        bit seen = 1'b0;
        if (!m) begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (m ? m1_done : m0_done) begin
                seen = 1'b1;
                break;
            end
        end
        check(m ? "m1_done_seen" : "m0_done_seen", 64'(seen), 64'(1));
        if (!keep) begin
            if (!m) m0_req = 1'b0;
            else    m1_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        mem_q.delete();
        done_q.delete();
        model_rd[0] = '0;
        model_rd[1] = '0;
        repeat (2) @(negedge clk);
        check_reset_zero();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Memory responder.
    initial begin
        resp_t r;
        logic  w;
        resp_rr = 1'b0;
        resp_sr = 1'b0;
        resp_data = '0;
        forever begin
            @(negedge clk);
            if (!rst && (mem_rd || mem_we) && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                w = mem_we;
                if (r.lat > 0) begin
                    repeat (r.lat) @(posedge clk);
                    #1;
                    if (w) resp_sr = 1'b1;
                    else begin
                        resp_rr = 1'b1;
                        resp_data = r.data;
                    end
                    @(posedge clk);
                    #1;
                    resp_rr = 1'b0;
                    resp_sr = 1'b0;
                    resp_data = '0;
                end
            end
        end
    end

    // Monitor.
    initial begin
        mem_exp_t  me;
        done_exp_t de;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_rd || mem_we) begin
                    check("strobe_excl", 64'(mem_rd & mem_we), 64'(0));
                    if (mem_q.size() == 0) check("unexpected_strobe", 64'(1), 64'(0));
                    else begin
                        me = mem_q.pop_front();
                        check("mem_we",    64'(mem_we), 64'(me.we));
                        check("mem_rd",    64'(mem_rd), 64'(!me.we));
                        check("mem_addr",  64'(mem_addr), 64'(me.addr));
                        check("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
                        check("gnt_issue", 64'(gnt), 64'(me.m ? 2'b10 : 2'b01));
                        issue_cyc = cyc;
                    end
                end
                if (m0_done || m1_done) begin
                    if (done_q.size() == 0) check("unexpected_done", 64'(1), 64'(0));
                    else begin
                        de = done_q.pop_front();
                        check("done_owner", 64'({m1_done, m0_done}), 64'(de.m ? 2'b10 : 2'b01));
                        check("done_err", 64'({m1_err, m0_err}),
                              64'(de.err ? (de.m ? 2'b10 : 2'b01) : 2'b00));
                        check("done_rdata", 64'(de.m ? m1_rdata : m0_rdata), 64'(de.rdata));
                        check("done_latency", 64'(cyc - issue_cyc), 64'(de.delta));
                        check("gnt_done", 64'(gnt), 64'(0));
                    end
                end
                if ((m0_err && !m0_done) || (m1_err && !m1_done))
                    check("err_without_done", 64'(1), 64'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        stray_rr = 1'b0;
        stray_sr = 1'b0;

        // 1: M0 read, ready two cycles after mem_rd.
        do_reset();
        push_access(1'b0, 1'b0, 15'h0123, 32'h0, 2, 32'hDEAD_BEEF);
        master_access(1'b0, 1'b0, 15'h0123, 32'h0, 1'b0);
        repeat (3) @(negedge clk);

        // 2: M1 write, saverdy after three cycles; m1_rdata stays 0.
        push_access(1'b1, 1'b1, 15'h1800, 32'hA5A5_0F0F, 3, 32'h0);
        master_access(1'b1, 1'b1, 15'h1800, 32'hA5A5_0F0F, 1'b0);
        repeat (3) @(negedge clk);

        // 3: both request together after reset; grants alternate starting with M0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_access(1'b0, t3_we0[i], t3_a0[i], t3_wd0[i], 1, t3_rd0[i]);
            push_access(1'b1, t3_we1[i], t3_a1[i], t3_wd1[i], 1, t3_rd1[i]);
        end
        fork
            begin
                for (int i = 0; i < 4; i++)
                    master_access(1'b0, t3_we0[i], t3_a0[i], t3_wd0[i], i < 3);
            end
            begin
                for (int j = 0; j < 4; j++)
                    master_access(1'b1, t3_we1[j], t3_a1[j], t3_wd1[j], j < 3);
            end
        join
        repeat (3) @(negedge clk);

        // 4: M0 read with no ready times out; a late readrdy is ignored; M1 then succeeds.
        push_access(1'b0, 1'b0, 15'h0042, 32'h0, 0, 32'h0);
        master_access(1'b0, 1'b0, 15'h0042, 32'h0, 1'b0);
        stray_rr = 1'b1;
        @(negedge clk);
        stray_rr = 1'b0;
        repeat (4) @(negedge clk);
        push_access(1'b1, 1'b0, 15'h0555, 32'h0, 2, 32'hCAFE_F00D);
        master_access(1'b1, 1'b0, 15'h0555, 32'h0, 1'b0);
        repeat (3) @(negedge clk);

        // 5: stray saverdy in IDLE and during a read WAIT; request changes mid-access.
        stray_sr = 1'b1;
        @(negedge clk);
        stray_sr = 1'b0;
        repeat (3) @(negedge clk);
        push_access(1'b0, 1'b0, 15'h0ABC, 32'h0, 4, 32'h5A5A_1234);
        fork
            master_access(1'b0, 1'b0, 15'h0ABC, 32'h0, 1'b0);
            begin
                seen = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (mem_rd) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("t5_mem_rd_seen", 64'(seen), 64'(1));
                @(posedge clk);
                #1;
                stray_sr = 1'b1;
                m0_addr  = 15'h7777;
                m0_we    = 1'b1;
                @(posedge clk);
                #1;
                stray_sr = 1'b0;
            end
        join
        repeat (3) @(negedge clk);

        // 6: reset during the WAIT of an M1 write aborts it without a done.
        mem_q.push_back('{1'b1, 1'b1, 15'h1234, 32'h1357_9BDF});
        resp_q.push_back('{6, 32'h0});
        m1_we = 1'b1; m1_addr = 15'h1234; m1_wdata = 32'h1357_9BDF; m1_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_we) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_mem_we_seen", 64'(seen), 64'(1));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_zero();
        m1_req = 1'b0;
        model_rd[0] = '0;
        model_rd[1] = '0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_access(1'b0, 1'b1, 15'h0100, 32'h0BAD_CAFE, 1, 32'h0);
        push_access(1'b1, 1'b0, 15'h0200, 32'h0, 2, 32'h8765_4321);
        fork
            master_access(1'b0, 1'b1, 15'h0100, 32'h0BAD_CAFE, 1'b0);
            master_access(1'b1, 1'b0, 15'h0200, 32'h0, 1'b0);
        join
        repeat (5) @(negedge clk);

        check("done_q_empty", 64'(done_q.size()), 64'(0));
        check("mem_q_empty",  64'(mem_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
